// File: rtl/rob_pkg.sv
// rob_pkg: shared widths, id type and entry layout for the reorder buffer.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
package rob_pkg;
    localparam int ROB_ID_W = 4;
    localparam int PHY_W    = `PHYSICAL_REG_NUM_WIDTH;
    localparam int ARCH_W   = `ARCH_REG_NUM_WIDTH;

    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              with_write;
        logic [ARCH_W-1:0] arch_wr_reg;
        logic [PHY_W-1:0]  phy_wr_reg;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue; allocates in program order,
// marks completions, retires the oldest done entry once per cycle.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_ID_WIDTH           = ROB_ID_W,
    parameter int PHYSICAL_REG_NUM_WIDTH = PHY_W,
    parameter int ARCH_REG_NUM_WIDTH     = ARCH_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid,
    input  logic                              alloc_with_write,
    input  logic [ARCH_REG_NUM_WIDTH-1:0]     alloc_arch_wr_reg,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_wr_reg,
    output logic                              alloc_ready,
    output logic [ROB_ID_WIDTH-1:0]           alloc_rob_id,
    input  logic                              complete_valid,
    input  logic [ROB_ID_WIDTH-1:0]           complete_rob_id,
    output logic                              commit_valid,
    output logic                              commit_with_write,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
    output logic [ROB_ID_WIDTH-1:0]           commit_rob_id,
    output logic [ROB_ID_WIDTH:0]             occupancy
);
    localparam int DEPTH = 1 << ROB_ID_WIDTH;

    rob_entry_t                entries_q [DEPTH];
    rob_entry_t                entries_d [DEPTH];
    rob_entry_t                head_e;
    logic [ROB_ID_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
    logic [ROB_ID_WIDTH:0]     count_q, count_d;
    logic                      do_alloc;

    always_comb begin
        head_e               = entries_q[head_q];
        alloc_ready          = count_q != (ROB_ID_WIDTH+1)'(DEPTH);
        alloc_rob_id         = tail_q;
        occupancy            = count_q;
        commit_valid         = head_e.valid && head_e.done;
        commit_with_write    = commit_valid && head_e.with_write;
        commited_wr_register = commit_valid ? head_e.phy_wr_reg : '0;
        commit_rob_id        = commit_valid ? head_q : '0;
        do_alloc             = alloc_valid && alloc_ready;
        entries_d            = entries_q;
        head_d               = head_q;
        tail_d               = tail_q;
        // Completion first so an entry allocated this same cycle cannot be marked done.
        if (complete_valid && entries_q[complete_rob_id].valid)
            entries_d[complete_rob_id].done = 1'b1;
        if (commit_valid) begin
            entries_d[head_q].valid = 1'b0;
            entries_d[head_q].done  = 1'b0;
            head_d                  = head_q + 1'b1;
        end
        if (do_alloc) begin
            entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, with_write: alloc_with_write,
                                  arch_wr_reg: alloc_arch_wr_reg, phy_wr_reg: alloc_phy_wr_reg};
            tail_d            = tail_q + 1'b1;
        end
        count_d = count_q + (ROB_ID_WIDTH+1)'(do_alloc) - (ROB_ID_WIDTH+1)'(commit_valid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: queue-based reference model with a decoupled commit scoreboard.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic              clk = 1'b0, reset = 1'b0;
    logic              alloc_valid = 1'b0, alloc_with_write = 1'b0;
    logic [ARCH_W-1:0] alloc_arch_wr_reg = '0;
    logic [PHY_W-1:0]  alloc_phy_wr_reg = '0;
    logic              alloc_ready;
    logic [3:0]        alloc_rob_id;
    logic              complete_valid = 1'b0;
    logic [3:0]        complete_rob_id = '0;
    logic              commit_valid, commit_with_write;
    logic [PHY_W-1:0]  commited_wr_register;
    logic [3:0]        commit_rob_id;
    logic [4:0]        occupancy;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_with_write(alloc_with_write),
        .alloc_arch_wr_reg(alloc_arch_wr_reg), .alloc_phy_wr_reg(alloc_phy_wr_reg),
        .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
        .complete_valid(complete_valid), .complete_rob_id(complete_rob_id),
        .commit_valid(commit_valid), .commit_with_write(commit_with_write),
        .commited_wr_register(commited_wr_register), .commit_rob_id(commit_rob_id),
        .occupancy(occupancy)
    );

    typedef struct { int id; bit ww; int phy; bit done; } inst_t;
    inst_t mq[$];
    inst_t exp_q[$];
    int    next_id = 0;
    int    passed = 0, total = 0;

    function automatic void chk(string name, longint act, longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Called at a falling edge: check outputs against the model, drive inputs, advance the model.
    task automatic step(bit av, bit ww, int phy, bit cv, int cid);
        int    sz;
        bit    pcv;
        inst_t n;
        sz  = mq.size();
        pcv = sz > 0 && mq[0].done;
        chk("alloc_ready", alloc_ready, sz < 16);
        chk("alloc_rob_id", alloc_rob_id, next_id);
        chk("occupancy", occupancy, sz);
        chk("commit_valid", commit_valid, pcv);
        if (!pcv) chk("commit_idle_zero", {commit_with_write, commited_wr_register, commit_rob_id}, 0);
        alloc_valid       = av;
        alloc_with_write  = ww;
        alloc_phy_wr_reg  = PHY_W'(ww ? phy : 0);
        alloc_arch_wr_reg = ARCH_W'($urandom);
        complete_valid    = cv;
        complete_rob_id   = 4'(cid);
        if (cv) foreach (mq[i]) if (mq[i].id == cid) mq[i].done = 1'b1;
        if (pcv) void'(mq.pop_front());
        if (av && sz < 16) begin
            n = '{id: next_id, ww: ww, phy: ww ? phy : 0, done: 1'b0};
            mq.push_back(n);
            exp_q.push_back(n);
            next_id = (next_id + 1) % 16;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        alloc_valid    = 1'b0;
        complete_valid = 1'b0;
        #1;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_rob_id", alloc_rob_id, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_fields", {commit_with_write, commited_wr_register, commit_rob_id}, 0);
        chk("rst_occupancy", occupancy, 0);
        mq.delete();
        exp_q.delete();
        next_id = 0;
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        inst_t e;
        if (reset && commit_valid) begin
            if (exp_q.size() == 0) chk("commit_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("commit_rob_id", commit_rob_id, e.id);
                chk("commit_with_write", commit_with_write, e.ww);
                chk("commited_wr_register", commited_wr_register, e.phy);
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        step(1, 1, 32, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(2);

        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 32 + i, 0, 0);
        step(0, 0, 0, 1, 2);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        idle(4);

        do_reset();
        for (int i = 0; i < 17; i++) step(1, 1, 16 + i, 0, 0);
        step(1, 1, 40, 1, 0);
        step(1, 1, 41, 0, 0);
        step(1, 1, 42, 0, 0);
        for (int i = 1; i < 16; i++) step(0, 0, 0, 1, i);
        idle(18);

        do_reset();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(2);

        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 50 + i, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 1, 60, 1, 12);
        idle(2);
        for (int i = 1; i < 6; i++) step(0, 0, 0, 1, i);
        idle(7);

        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 20 + i, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 2);
        do_reset();
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            int ap, cp;
            ap = ((i / 400) % 2 == 0) ? 80 : 25;
            cp = ((i / 400) % 2 == 0) ? 30 : 85;
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 99) < ap, 1'($urandom), int'($urandom_range(1, 63)),
                      $urandom_range(0, 99) < cp, int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement queue directly downstream of rename. Allocates one entry per renamed instruction in program order, marks entries done when execution reports completion, and retires the oldest done entry once per cycle.
- Retirement drives the rename stage's commit interface: commit_valid, commit_with_write and commited_wr_register. Rename then frees the superseded physical register.

Parameters:
- ROB_ID_WIDTH, 4, log2 of entry count (16 entries)
- PHYSICAL_REG_NUM_WIDTH, `PHYSICAL_REG_NUM_WIDTH, physical register id width
- ARCH_REG_NUM_WIDTH, `ARCH_REG_NUM_WIDTH, architectural register id width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- alloc_valid  in  1  rename presents an instruction this cycle
- alloc_with_write  in  1  instruction writes a register
- alloc_arch_wr_reg  in  ARCH_REG_NUM_WIDTH  destination arch register (debug/trace only)
- alloc_phy_wr_reg  in  PHYSICAL_REG_NUM_WIDTH  newly mapped physical destination
- alloc_ready  out  1  an entry is free; allocation accepted when alloc_valid && alloc_ready
- alloc_rob_id  out  ROB_ID_WIDTH  id given to the accepted instruction (= tail)
- complete_valid  in  1  execution finished an instruction
- complete_rob_id  in  ROB_ID_WIDTH  id of the finished instruction
- commit_valid  out  1  head entry retires this cycle
- commit_with_write  out  1  retiring entry wrote a register
- commited_wr_register  out  PHYSICAL_REG_NUM_WIDTH  physical destination of the retiring entry
- commit_rob_id  out  ROB_ID_WIDTH  id of the retiring entry
- occupancy  out  ROB_ID_WIDTH+1  number of valid entries

Behaviour:
- Storage: 2^ROB_ID_WIDTH entries of {valid, done, with_write, arch_wr_reg, phy_wr_reg}. State is head ptr, tail ptr and count (ROB_ID_WIDTH+1 bits). Pointers wrap modulo 2^ROB_ID_WIDTH.
- Reset (reset==0, asynchronous):
  - head=tail=count=0; all entries valid=0, done=0.
  - Outputs: alloc_ready=1, alloc_rob_id=0, commit_valid=0, commit_with_write=0, commited_wr_register=0, commit_rob_id=0, occupancy=0.
  - Reset asserted mid-operation discards all in-flight entries; nothing is committed.
- alloc_ready = (count != 2^ROB_ID_WIDTH). It is combinational from registered count and does NOT account for a same-cycle commit. A full ROB therefore stalls one cycle even when the head retires.
- Allocate on a rising edge when alloc_valid && alloc_ready:
  - entry[tail] <= {1, 0, alloc_with_write, alloc_arch_wr_reg, alloc_phy_wr_reg}; tail <= tail+1.
  - alloc_rob_id always shows the current tail.
  - alloc_valid while full is dropped with no state change; rename must hold the instruction.
- Complete on a rising edge when complete_valid && entry[complete_rob_id].valid: done <= 1.
  - Completion of an invalid entry is ignored.
  - A repeated completion is idempotent.
- Commit: combinational from registered state.
  - commit_valid = entry[head].valid && entry[head].done.
  - commit_with_write, commited_wr_register and commit_rob_id are taken from the head entry. They are 0 when commit_valid=0.
  - On the edge with commit_valid: entry[head].valid <= 0, done <= 0, head <= head+1.
  - At most one commit per cycle.
- Latency:
  - A completion at edge N makes commit visible in the cycle after N, provided the entry is at head.
  - Allocation-to-commit takes at least 2 edges (alloc edge, then complete edge).
- Simultaneous events:
  - Alloc + commit in the same cycle: count unchanged, both pointers advance.
  - Complete of the head entry + commit of a different entry cannot coincide, since only the head commits.
  - Complete targeting the head while commit_valid=0: done is set; commit follows next cycle.
- Ordering: commits strictly in allocation order regardless of completion order.
- Non-writing entries commit with commit_with_write=0. Rename then frees nothing.

Decomposition:
- Shared package rob_pkg:
  - ROB_ID_WIDTH default.
  - Typedef rob_entry_t {valid, done, with_write, arch_wr_reg, phy_wr_reg}.
  - Typedef rob_id_t.
- No sub-module; pointer/count logic and the entry array are kept inline (single always_comb + always_ff).

Test Plan:
- Reset → alloc_ready=1, occupancy=0, commit_valid=0. Alloc phy 32, then complete id 0 → commit_valid=1, commited_wr_register=32 one cycle after the complete edge.
- Alloc ids 0,1,2 (phy 32,33,34); complete 2, then 1, then 0 → commits appear in order 32,33,34 on three consecutive cycles after id 0 completes.
- Fill 16 entries → alloc_ready=0, occupancy=16; a 17th alloc_valid is dropped with tail unchanged. Complete id 0 → commit, and the next cycle alloc_ready=1 with alloc_rob_id=0 (wrap).
- Alloc with_write=0 and complete it → commit_valid=1, commit_with_write=0, commited_wr_register=0.
- Alloc + commit in the same cycle with occupancy=5 → occupancy stays 5, head and tail each +1. complete_rob_id pointing at an empty entry → no change.
- 4 entries allocated, 2 done, reset pulsed low mid-stream → all outputs return to reset values immediately, and no commit occurs after release.
